// File: rtl/spi_pkg.sv
// Shared types for the SPI master controller: FSM state encoding, latched
// per-frame mode bits and the divider value used before the first frame.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  localparam int unsigned SPI_DEFAULT_DIV = 1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI master. The counter is reloaded by the FSM
// at every state/edge boundary; tick marks the last clk cycle of a half-period.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  // Down-count towards zero, restart from div_i whenever a new half-period begins.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= div_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: turns a valid/ready word stream into SPI frames on
// sclk/cs_n/mosi with all four CPOL/CPHA modes, selectable bit order, a
// programmable half-period and chip-select hold across frames.
// Optional feature macro: SPI_MASTER_CTRL_RX_EN enables the miso capture path
// (rx_valid/rx_data); without it those outputs are tied to zero.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_CS = 2,
  parameter  int DIV_W  = 8,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   tx_cs_sel,
  input  logic              tx_hold_cs,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int IDX_W     = $clog2(DATA_W);
  localparam int EC_W      = $clog2(2 * DATA_W + 1);
  localparam int LAST_EDGE = 2 * DATA_W - 1;

  spi_state_e        state_q;
  spi_mode_t         mode_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [CS_W-1:0]   sel_q;
  logic              hold_q;
  logic              held_q;
  logic [EC_W-1:0]   edge_q;
  logic              sclk_q;
  logic              mosi_q;
  logic [NUM_CS-1:0] cs_n_q;

  logic              tick;
  logic              accept;
  logic              leading;
  logic [IDX_W-1:0]  shift_idx;
  logic [DIV_W-1:0]  div_src;

  // Position in the word of the b-th bit on the wire.
  function automatic logic [IDX_W-1:0] bit_idx(input logic lsb, input int b);
    return lsb ? IDX_W'(b) : IDX_W'(DATA_W - 1 - b);
  endfunction

  // One-cold chip-select pattern; an out-of-range index selects nothing.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign tx_ready  = (state_q == IDLE);
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state_q != IDLE) || held_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;
  // The next edge is leading when an even number of edges has gone by.
  assign leading   = ~edge_q[0];
  // CPHA=1 drives bit n on leading edge 2n+1; CPHA=0 drives bit n+1 on trailing edge 2n+2.
  assign shift_idx = bit_idx(mode_q.lsb_first, int'(edge_q >> 1) + (mode_q.cpha ? 0 : 1));
  // The frame's divider is taken straight from the port in the accept cycle.
  assign div_src   = accept ? cfg_div : div_q;

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept || (tick && (state_q != IDLE))),
    .div_i  (div_src),
    .tick_o (tick)
  );

  // Frame sequencer: latches the request, walks the SCLK edges, drives mosi and cs_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      div_q     <= DIV_W'(SPI_DEFAULT_DIV);
      tx_data_q <= '0;
      sel_q     <= '0;
      hold_q    <= 1'b0;
      held_q    <= 1'b0;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q    <= '{cpol: cfg_cpol, cpha: cfg_cpha, lsb_first: cfg_lsb_first};
            div_q     <= cfg_div;
            tx_data_q <= tx_data;
            sel_q     <= tx_cs_sel;
            hold_q    <= tx_hold_cs;
            held_q    <= 1'b0;
            edge_q    <= '0;
            sclk_q    <= cfg_cpol;
            mosi_q    <= cfg_cpha ? 1'b0 : tx_data[bit_idx(cfg_lsb_first, 0)];
            if (held_q && (tx_cs_sel == sel_q)) begin
              state_q <= XFER;
            end else begin
              cs_n_q  <= cs_decode(tx_cs_sel);
              state_q <= SETUP;
            end
          end
        end
        SETUP: if (tick) state_q <= XFER;
        XFER: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 1'b1;
            if (leading && mode_q.cpha) mosi_q <= tx_data_q[shift_idx];
            if (!leading && !mode_q.cpha && (edge_q != EC_W'(LAST_EDGE)))
              mosi_q <= tx_data_q[shift_idx];
            if (edge_q == EC_W'(LAST_EDGE)) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_q) begin
              held_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cs_n_q  <= '1;
              state_q <= GAP;
            end
          end
        end
        GAP:     if (tick) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_CTRL_RX_EN
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic [IDX_W-1:0]  samp_idx;

  // Bit n is sampled on edge 2n+1 (CPHA=0) or 2n+2 (CPHA=1); both give edge_q>>1.
  assign samp_idx = bit_idx(mode_q.lsb_first, int'(edge_q >> 1));

  // Capture miso on sample edges and publish the word as HOLD ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if ((state_q == XFER) && tick && (leading != mode_q.cpha)) rx_sh_q[samp_idx] <= miso;
      if ((state_q == HOLD) && tick) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= rx_sh_q;
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_valid    = 1'b0;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl. A bus-level slave model watches
// sclk transitions, collects mosi bits on sample edges, presents miso bits and
// predicts latencies, chip-select and busy behaviour from the frame rules.
module tb_spi_master_ctrl;

  localparam int W   = 8;
  localparam int NCS = 3;
  localparam int CSW = 2;
  localparam int DW  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic [DW-1:0]  cfg_div;
  logic           tx_valid;
  logic           tx_ready;
  logic [W-1:0]   tx_data;
  logic [CSW-1:0] tx_cs_sel;
  logic           tx_hold_cs;
  logic           rx_valid;
  logic [W-1:0]   rx_data;
  logic           busy;
  logic           sclk;
  logic [NCS-1:0] cs_n;
  logic           mosi;
  logic           miso;

  logic           loop_en   = 1'b0;
  logic           slave_bit = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference state: is a chip select held from the previous frame, and which one.
  bit m_held = 1'b0;
  int m_sel  = 0;

  assign miso = loop_en ? mosi : slave_bit;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DATA_W(W), .NUM_CS(NCS), .DIV_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_cpol      (cfg_cpol),
    .cfg_cpha      (cfg_cpha),
    .cfg_lsb_first (cfg_lsb_first),
    .cfg_div       (cfg_div),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_cs_sel     (tx_cs_sel),
    .tx_hold_cs    (tx_hold_cs),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .busy          (busy),
    .sclk          (sclk),
    .cs_n          (cs_n),
    .mosi          (mosi),
    .miso          (miso)
  );

  // Runs one frame and checks latency, SCLK edge count, the word seen on mosi,
  // chip select and busy in every cycle, and the received word.
  task automatic run_frame(input logic [W-1:0] data, input int sel, input bit hold,
                           input bit cpol, input bit cpha, input bit lsb, input int div,
                           input bit loop, input logic [W-1:0] sword, input bit chain,
                           input string tag);
    int h, lat, rdy, k, k_rx, k_rdy, edges, nbits, pulses, waitc;
    bit skip, cs_bad, busy_bad, done;
    logic prev_sclk, prev_mosi;
    logic [W-1:0] got_mosi, got_rx, exp_rx;
    logic [NCS-1:0] exp_cs;

    h      = div + 1;
    skip   = m_held && (sel == m_sel);
    lat    = skip ? h * (2 * W + 1) : h * (2 * W + 2);
    rdy    = hold ? lat : lat + h;
    exp_cs = '1;
    if (sel < NCS) exp_cs[sel] = 1'b0;
    exp_rx = loop ? data : sword;

    waitc = 0;
    while (tx_ready !== 1'b1 && waitc < 500) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept got=%b want=1", tag, tx_ready);
    end

    tx_valid      = 1'b1;
    tx_data       = data;
    tx_cs_sel     = CSW'(sel);
    tx_hold_cs    = hold;
    cfg_cpol      = cpol;
    cfg_cpha      = cpha;
    cfg_lsb_first = lsb;
    cfg_div       = DW'(div);
    loop_en       = loop;
    slave_bit     = lsb ? sword[0] : sword[W-1];

    @(posedge clk);
    k = 0; edges = 0; nbits = 0; pulses = 0; k_rx = -1; k_rdy = -1;
    cs_bad = 1'b0; busy_bad = 1'b0; done = 1'b0;
    got_mosi = '0; got_rx = '0; prev_sclk = 1'b0; prev_mosi = 1'b0;
    while (!done && k < 600) begin
      @(negedge clk);
      if (k == 0) begin
        // Scramble the request inputs: the frame must run on its latched copy.
        tx_valid      = chain;
        tx_data       = W'($urandom);
        tx_cs_sel     = CSW'($urandom);
        tx_hold_cs    = 1'($urandom);
        cfg_cpol      = 1'($urandom);
        cfg_cpha      = 1'($urandom);
        cfg_lsb_first = 1'($urandom);
        cfg_div       = DW'($urandom);
        checks++;
        if (sclk !== cpol) begin
          errors++;
          $display("FAIL %s sclk_after_accept got=%b want=%b", tag, sclk, cpol);
        end
      end else if (sclk !== prev_sclk) begin
        edges++;
        // Sample edge: leading for CPHA=0, trailing for CPHA=1.
        if ((prev_sclk == cpol) != cpha) begin
          if (nbits < W) got_mosi[lsb ? nbits : W - 1 - nbits] = prev_mosi;
          nbits++;
          if (nbits < W) slave_bit = lsb ? sword[nbits] : sword[W - 1 - nbits];
        end
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
      if (rx_valid === 1'b1) begin
        pulses++;
        if (k_rx < 0) begin
          k_rx   = k;
          got_rx = rx_data;
        end
      end
      if (cs_n !== (((k < lat) || hold) ? exp_cs : {NCS{1'b1}})) cs_bad = 1'b1;
      if (busy !== ((k < rdy) || hold)) busy_bad = 1'b1;
      if (tx_ready === 1'b1) begin
        k_rdy = k;
        done  = 1'b1;
      end else begin
        k++;
      end
    end

    checks++;
    if (k_rdy != rdy) begin
      errors++;
      $display("FAIL %s ready_latency got=%0d want=%0d", tag, k_rdy, rdy);
    end
    checks++;
    if (edges != 2 * W) begin
      errors++;
      $display("FAIL %s sclk_edges got=%0d want=%0d", tag, edges, 2 * W);
    end
    checks++;
    if (got_mosi !== data) begin
      errors++;
      $display("FAIL %s mosi_word got=%h want=%h", tag, got_mosi, data);
    end
    checks++;
    if (cs_bad) begin
      errors++;
      $display("FAIL %s cs_n_during_frame got=deviation want=%b_then_%s", tag, exp_cs,
               hold ? "held" : "released");
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy_during_frame got=deviation want=high_for_%0d_cycles", tag, rdy);
    end
    checks++;
    if (sclk !== cpol) begin
      errors++;
      $display("FAIL %s sclk_idle_after got=%b want=%b", tag, sclk, cpol);
    end
`ifdef SPI_MASTER_CTRL_RX_EN
    checks++;
    if (k_rx != lat) begin
      errors++;
      $display("FAIL %s rx_latency got=%0d want=%0d", tag, k_rx, lat);
    end
    checks++;
    if (got_rx !== exp_rx) begin
      errors++;
      $display("FAIL %s rx_data got=%h want=%h", tag, got_rx, exp_rx);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL %s rx_valid_pulses got=%0d want=1", tag, pulses);
    end
`else
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL %s rx_valid_pulses got=%0d want=0", tag, pulses);
    end
    checks++;
    if (rx_data !== '0) begin
      errors++;
      $display("FAIL %s rx_data_tied got=%h want=00", tag, rx_data);
    end
`endif
    if (!chain) begin
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s rx_valid_after got=%b want=0", tag, rx_valid);
      end
`ifdef SPI_MASTER_CTRL_RX_EN
      checks++;
      if (rx_data !== exp_rx) begin
        errors++;
        $display("FAIL %s rx_data_stable got=%h want=%h", tag, rx_data, exp_rx);
      end
`endif
    end
    m_held  = hold;
    m_sel   = sel;
    loop_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_cs_sel = '0; tx_hold_cs = 1'b0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_div = '0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (sclk !== 1'b0) begin errors++; $display("FAIL reset sclk got=%b want=0", sclk); end
    if (cs_n !== '1) begin errors++; $display("FAIL reset cs_n got=%b want=111", cs_n); end
    if (mosi !== 1'b0) begin errors++; $display("FAIL reset mosi got=%b want=0", mosi); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset tx_ready got=%b want=1", tx_ready); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset rx_valid got=%b want=0", rx_valid); end
    if (rx_data !== '0) begin errors++; $display("FAIL reset rx_data got=%h want=00", rx_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b want=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0_loopback();
    run_frame(8'hA5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h00, 1'b0, "mode0_loop");
  endtask

  task automatic test_mode3_lsb();
    run_frame(8'h01, 1, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0, 8'hFF, 1'b0, "mode3_lsb");
  endtask

  task automatic test_cs_hold();
    run_frame(8'h12, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, W'($urandom), 1'b0, "hold_first");
    run_frame(8'h34, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 8'h00, 1'b0, "hold_second");
  endtask

  task automatic test_sel_change();
    run_frame(W'($urandom), 0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h00, 1'b0, "selchg_first");
    run_frame(W'($urandom), 1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, W'($urandom), 1'b0, "selchg_second");
  endtask

  task automatic test_out_of_range();
    run_frame(W'($urandom), 3, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, W'($urandom), 1'b0, "sel_oor");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_frame(W'($urandom), 2, i < 3, 1'b0, 1'b0, 1'b0, 0, 1'b0, W'($urandom), i < 3, "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++)
      run_frame(W'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                W'($urandom), 1'b0, "random");
  endtask

  task automatic test_reset_mid_frame();
    int e, k;
    logic ps;
    bit seen;
    tx_valid = 1'b1; tx_data = W'($urandom); tx_cs_sel = 2'd0; tx_hold_cs = 1'b0;
    cfg_cpol = 1'b1; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_div = 8'd1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    ps = sclk; e = 0; k = 0;
    while (e < 5 && k < 200) begin
      @(negedge clk);
      if (sclk !== ps) e++;
      ps = sclk;
      k++;
    end
    checks++;
    if (e != 5) begin errors++; $display("FAIL rst_mid edges_before_reset got=%0d want=5", e); end
    #1 rst_n = 1'b0;
    #1;
    checks += 5;
    if (sclk !== 1'b0) begin errors++; $display("FAIL rst_mid sclk got=%b want=0", sclk); end
    if (cs_n !== '1) begin errors++; $display("FAIL rst_mid cs_n got=%b want=111", cs_n); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_mid tx_ready got=%b want=1", tx_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got=%b want=0", busy); end
    if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mid mosi got=%b want=0", mosi); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (rx_valid !== 1'b0 || tx_ready !== 1'b1 || sclk !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_mid quiet_after got=activity want=idle"); end
    m_held = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_mode3_lsb();
    test_cs_hold();
    test_sel_change();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
